// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with a valid/ready sequencer.
// MUL/DIV hold the issuing stage for a fixed number of cycles.
module alu_ctrl_seq #(
    parameter int FUNCT_W    = 6,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    output logic               ready,
    input  logic [1:0]         ALUOp,
    input  logic [FUNCT_W-1:0] funct,
    output logic [CTRL_W-1:0]  ALUctrl,
    output logic               valid_out,
    output logic               busy,
    output logic               illegal
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] C_OR  = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] C_XOR = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] C_SLT = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] C_SLL = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] C_SRL = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] C_MUL = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] C_DIV = CTRL_W'(9);

    typedef enum logic {
        IDLE,
        MULTI
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CTRL_W-1:0]  ctrl_nxt;
    logic               ill_nxt;
    logic               vout_nxt;

    logic [CTRL_W-1:0]  dec_code;
    logic               dec_ill;
    logic               dec_multi;
    logic [CNT_W-1:0]   dec_cnt;

    always_comb begin
        dec_code  = C_ADD;
        dec_ill   = 1'b0;
        dec_multi = 1'b0;
        dec_cnt   = '0;
        case (ALUOp)
            2'b00: dec_code = C_ADD;
            2'b01: dec_code = C_SUB;
            2'b11: dec_code = C_XOR;
            default: begin
                if (funct == FUNCT_W'(6'b100000)) begin
                    dec_code = C_ADD;
                end else if (funct == FUNCT_W'(6'b100010)) begin
                    dec_code = C_SUB;
                end else if (funct == FUNCT_W'(6'b100100)) begin
                    dec_code = C_AND;
                end else if (funct == FUNCT_W'(6'b100101)) begin
                    dec_code = C_OR;
                end else if (funct == FUNCT_W'(6'b100110)) begin
                    dec_code = C_XOR;
                end else if (funct == FUNCT_W'(6'b101010)) begin
                    dec_code = C_SLT;
                end else if (funct == FUNCT_W'(6'b000000)) begin
                    dec_code = C_SLL;
                end else if (funct == FUNCT_W'(6'b000010)) begin
                    dec_code = C_SRL;
                end else if (funct == FUNCT_W'(6'b011000)) begin
                    dec_code  = C_MUL;
                    dec_multi = 1'b1;
                    dec_cnt   = CNT_W'(MUL_CYCLES - 1);
                end else if (funct == FUNCT_W'(6'b011010)) begin
                    dec_code  = C_DIV;
                    dec_multi = 1'b1;
                    dec_cnt   = CNT_W'(DIV_CYCLES - 1);
                end else begin
                    dec_code = C_ADD;
                    dec_ill  = 1'b1;
                end
            end
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state == MULTI);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ctrl_nxt  = ALUctrl;
        ill_nxt   = illegal;
        vout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    ctrl_nxt = dec_code;
                    ill_nxt  = dec_ill;
                    if (dec_multi) begin
                        state_nxt = MULTI;
                        cnt_nxt   = dec_cnt;
                    end else begin
                        vout_nxt = 1'b1;
                    end
                end
            end
            MULTI: begin
                // Last count: completion coincides with ready returning high
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    vout_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ALUctrl   <= '0;
            illegal   <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ALUctrl   <= ctrl_nxt;
            illegal   <= ill_nxt;
            valid_out <= vout_nxt;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized bench for alu_ctrl_seq against a cycle-indexed
// transaction model (accept time + latency -> completion time).
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic       ready;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic [3:0] alu_ctrl;
    logic       valid_out;
    logic       busy;
    logic       illegal;

    always #5 clk = ~clk;

    alu_ctrl_seq dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready     (ready),
        .ALUOp     (alu_op),
        .funct     (funct),
        .ALUctrl   (alu_ctrl),
        .valid_out (valid_out),
        .busy      (busy),
        .illegal   (illegal)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_until;
    int valid_at;
    int m_ctrl;
    bit m_ill;
    bit known = 1'b0;
    int ftab [64];
    logic [5:0] legal [10];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic void decode(input logic [1:0] op, input logic [5:0] f,
                                   output int code, output bit ill,
                                   output int lat);
        ill = 1'b0;
        case (op)
            2'd0: code = 0;
            2'd1: code = 1;
            2'd3: code = 4;
            default: begin
                if (ftab[f] < 0) begin
                    code = 0;
                    ill  = 1'b1;
                end else begin
                    code = ftab[f];
                end
            end
        endcase
        lat = (code == 8) ? 4 : (code == 9) ? 8 : 1;
    endfunction

    task automatic step(input bit r, input bit v, input logic [1:0] op,
                        input logic [5:0] f);
        int code;
        bit ill;
        int lat;
        @(negedge clk);
        if (known) begin
            chk("ready", 32'(ready), 32'(cyc >= busy_until));
            chk("busy", 32'(busy), 32'(cyc < busy_until));
            chk("valid_out", 32'(valid_out), 32'(cyc == valid_at));
            chk("ALUctrl", 32'(alu_ctrl), 32'(m_ctrl));
            chk("illegal", 32'(illegal), 32'(m_ill));
        end
        rst      = r;
        valid_in = v;
        alu_op   = op;
        funct    = f;
        if (r) begin
            known      = 1'b1;
            busy_until = 0;
            valid_at   = -1;
            m_ctrl     = 0;
            m_ill      = 1'b0;
        end else if (known && v && cyc >= busy_until) begin
            decode(op, f, code, ill, lat);
            m_ctrl     = code;
            m_ill      = ill;
            valid_at   = cyc + lat;
            busy_until = cyc + lat;
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ftab[i] = -1;
        ftab[6'b100000] = 0;
        ftab[6'b100010] = 1;
        ftab[6'b100100] = 2;
        ftab[6'b100101] = 3;
        ftab[6'b100110] = 4;
        ftab[6'b101010] = 5;
        ftab[6'b000000] = 6;
        ftab[6'b000010] = 7;
        ftab[6'b011000] = 8;
        ftab[6'b011010] = 9;
        legal = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                  6'b101010, 6'b000000, 6'b000010, 6'b011000, 6'b011010};

        rst = 1'b1; valid_in = 1'b0; alu_op = 2'b00; funct = 6'b0;

        step(1, 0, 2'b00, 6'b0);
        step(1, 0, 2'b00, 6'b0);
        step(0, 0, 2'b00, 6'b0);
        step(0, 1, 2'b10, 6'b101010);
        step(0, 1, 2'b00, 6'b0);
        step(0, 1, 2'b01, 6'b0);
        step(0, 1, 2'b11, 6'b010101);
        step(0, 1, 2'b10, 6'b011000);
        for (int i = 0; i < 4; i++) step(0, 1, 2'b00, 6'b0);
        step(0, 1, 2'b10, 6'b111111);
        step(0, 0, 2'b00, 6'b0);
        step(0, 1, 2'b10, 6'b011010);
        step(0, 0, 2'b00, 6'b0);
        step(0, 0, 2'b00, 6'b0);
        step(1, 0, 2'b00, 6'b0);
        for (int i = 0; i < 10; i++) step(0, 0, 2'b00, 6'b0);
        step(0, 1, 2'b10, 6'b011010);
        for (int i = 0; i < 9; i++) step(0, 0, 2'b00, 6'b0);

        for (int i = 0; i < 3000; i++) begin
            logic [5:0] f;
            if ($urandom_range(0, 9) < 8)
                f = legal[$urandom_range(0, 9)];
            else
                f = 6'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
                 2'($urandom), f);
        end
        step(0, 0, 2'b00, 6'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
